scalar_operand_stage: RTL and testbench
=======================================

Name: scalar_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the scalar ALU.
- Takes decoded instructions and register-file read data, and resolves operand hazards:
  - forwarding from the EX stage and from the WB stage;
  - a one-cycle load-use bubble.
- Registers operand A, operand B and op, which drive the ALU inputs.
- Handles downstream stall and pipeline flush, and keeps a saturating stall-cycle counter.

Parameters:
- DATA_W, 36, operand/result width (matches ALU)
- REG_W, 5, register index width (32 registers, r0 reads as zero)
- OP_W, 4, ALU opcode width; op[3]=1 marks flag-setting (compare) ops
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  this stage accepts the instruction this cycle
- id_op  in  OP_W  ALU opcode
- id_rs1, id_rs2  in  REG_W  source register indices
- id_rd  in  REG_W  destination index
- id_rd_we  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load (ALU computes the address)
- id_use_imm  in  1  operand B comes from id_imm
- id_imm  in  DATA_W  sign-extended immediate
- rf_rdata1, rf_rdata2  in  DATA_W  register-file read data for rs1/rs2
- alu_result  in  DATA_W  combinational ALU output for the instruction currently in EX
- wb_we  in  1  writeback stage writes a register
- wb_rd  in  REG_W  writeback destination index
- wb_data  in  DATA_W  writeback data
- ex_stall  in  1  downstream hold; EX registers must not change
- flush  in  1  squash the instruction entering EX
- ex_valid  out  1  EX registers hold a live instruction
- ex_a, ex_b  out  DATA_W  ALU operands
- ex_op  out  OP_W  ALU opcode
- ex_rd  out  REG_W  destination index
- ex_we  out  1  register write enable
- ex_is_load  out  1  load marker
- stall_cnt  out  CNT_W  count of load-use bubble cycles

Behaviour:
- Reset (rst_n=0 at clk edge): all ex_* outputs 0 and stall_cnt 0. Reset applied mid-operation discards the in-flight instruction.
- Load-use hazard is asserted when all of the following hold:
  - id_valid & ex_valid & ex_is_load & ex_we;
  - ex_rd != 0;
  - id_rs1 == ex_rd, or (id_rs2 == ex_rd and id_use_imm = 0).
- id_ready = flush | (~ex_stall & ~hazard). This is combinational; no dependence on id_valid.
- EX register update, evaluated in priority order:
  1. flush: ex_valid<=0, ex_we<=0. The ID instruction is consumed and dropped. Flush overrides ex_stall.
  2. ex_stall: hold all EX registers.
  3. hazard: insert a bubble (ex_valid<=0, ex_we<=0). The ID instruction is retried the next cycle.
  4. id_valid: capture the instruction. ex_we <= id_rd_we & ~id_op[3] & (id_rd != 0), because compare ops write only flags.
  5. otherwise: ex_valid<=0, ex_we<=0.
- Data fields (ex_a/b/op/rd/is_load) may hold stale values whenever ex_valid=0. The bench checks them only when ex_valid=1.
- Operand forwarding, per source, in priority order:
  - rs==0 gives 0;
  - else, if ex_valid & ex_we & ~ex_is_load & ex_rd==rs, gives alu_result;
  - else, if wb_we & wb_rd==rs, gives wb_data;
  - else gives rf_rdata.
- ex_a = forwarded rs1. ex_b = id_use_imm ? id_imm : forwarded rs2.
- Forwarding is evaluated in the capture cycle only. It is not re-evaluated while stalled; the upstream pipeline must hold WB across ex_stall.
- Latency: one cycle from accepted ID to valid EX outputs. Throughput is one instruction per cycle with no hazard.
- stall_cnt increments in each cycle that a hazard bubble is inserted (priority case 3). It saturates at all-ones and does not count flush or ex_stall cycles.
- Simultaneous hazard and ex_stall: stall wins, so no bubble is inserted and the counter is not incremented.

Decomposition:
- Package scalar_pkg holds:
  - DATA_W, REG_W, OP_W;
  - an opcode enum: ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, SHL=6, SHR=7, with compare ops in 8–15;
  - an id_instr_t struct bundling the id_* fields.
- One sub-module, operand_fwd_mux (rs, rf_rdata, EX/WB bypass inputs gives operand), instantiated for rs1 and rs2.

Test Plan:
1. Back-to-back ADD r3=r1+r2 then SUB r4=r3-r1 (rf r1=5, r2=7, stale r3=0): second ex_a=12 from alu_result, ex_b=5, with no bubble.
2. Load r5 in EX, then ADD r6=r5+r1: one bubble, so id_ready=0 for one cycle, ex_valid=0 and stall_cnt 0→1. The next cycle ADD is captured with no EX forward.
3. wb_we=1, wb_rd=2, wb_data=0x9_0000_0001 with rf_rdata2=0 and no EX match: ex_b=0x9_0000_0001. Source rs=0 with wb_rd=0 written: operand stays 0.
4. ex_stall held 3 cycles with id_valid=1: EX outputs unchanged and id_ready=0. Assert flush during the stall: next ex_valid=0 and id_ready=1.
5. Compare op (op=4'b1000) with id_rd_we=1, id_rd=7: ex_we=0. id_use_imm=1, imm=0xFFFFFFFFF: ex_b=0xFFFFFFFFF regardless of rs2.
6. Force stall_cnt to 0xFFFF and trigger another hazard: counter stays 0xFFFF. Pulse rst_n=0 mid-stream: all outputs 0 at the next edge.

Source files
------------

// File: rtl/scalar_pkg.sv
// Shared widths, ALU opcode encoding and the pipeline bundles used by the
// scalar ID/EX operand stage.
package scalar_pkg;

  localparam int DATA_W = 36;
  localparam int REG_W  = 5;
  localparam int OP_W   = 4;

  // The top opcode bit marks compare ops, which update flags and never a register.
  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_MUL     = 4'd2,
    OP_AND     = 4'd3,
    OP_OR      = 4'd4,
    OP_XOR     = 4'd5,
    OP_SHL     = 4'd6,
    OP_SHR     = 4'd7,
    OP_CMP_EQ  = 4'd8,
    OP_CMP_NE  = 4'd9,
    OP_CMP_LT  = 4'd10,
    OP_CMP_GE  = 4'd11,
    OP_CMP_LTU = 4'd12,
    OP_CMP_GEU = 4'd13,
    OP_CMP_GT  = 4'd14,
    OP_CMP_LE  = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              rd_we;
    logic              is_load;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
  } id_instr_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              is_load;
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } ex_state_t;

  function automatic logic is_flag_op(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Selects one source operand: hard zero for r0, then the EX bypass, then the
// WB bypass, then the register-file read data.
module operand_fwd_mux
  import scalar_pkg::*;
(
  input  logic [REG_W-1:0]  rs,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              ex_fwd_en,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);

  // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    operand = rf_rdata;
    if (rs == '0) begin
      operand = '0;
    end else if (ex_fwd_en && (ex_rd == rs)) begin
      operand = ex_data;
    end else if (wb_we && (wb_rd == rs)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/scalar_operand_stage.sv
// ID/EX stage feeding the scalar ALU: operand forwarding, load-use bubble,
// downstream stall/flush handling and a saturating bubble counter.
module scalar_operand_stage
  import scalar_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              id_use_imm,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [OP_W-1:0]   ex_op,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_we,
  output logic              ex_is_load,
  output logic [CNT_W-1:0]  stall_cnt
);

  id_instr_t         id;
  ex_state_t         ex_q;
  logic [CNT_W-1:0]  stall_q;
  logic              hazard;
  logic              ex_fwd_en;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  assign id = '{op: id_op, rs1: id_rs1, rs2: id_rs2, rd: id_rd, rd_we: id_rd_we,
                is_load: id_is_load, use_imm: id_use_imm, imm: id_imm};

  // A load's value is not available until WB, so a dependent instruction waits one cycle.
  assign hazard = id_valid & ex_q.valid & ex_q.is_load & ex_q.we & (ex_q.rd != '0) &
                  ((id.rs1 == ex_q.rd) | (~id.use_imm & (id.rs2 == ex_q.rd)));

  assign id_ready = flush | (~ex_stall & ~hazard);

  // alu_result of a load in EX is its address, never the register value.
  assign ex_fwd_en = ex_q.valid & ex_q.we & ~ex_q.is_load;

  operand_fwd_mux u_fwd_a (
    .rs        (id.rs1),
    .rf_rdata  (rf_rdata1),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_q.rd),
    .ex_data   (alu_result),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .operand   (fwd_a)
  );

  operand_fwd_mux u_fwd_b (
    .rs        (id.rs2),
    .rf_rdata  (rf_rdata2),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_q.rd),
    .ex_data   (alu_result),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .operand   (fwd_b)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      stall_q <= '0;
    end else if (flush) begin
      ex_q.valid <= 1'b0;
      ex_q.we    <= 1'b0;
    end else if (!ex_stall) begin
      if (hazard) begin
        ex_q.valid <= 1'b0;
        ex_q.we    <= 1'b0;
        if (stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      end else if (id_valid) begin
        ex_q <= '{valid:   1'b1,
                  we:      id.rd_we & ~is_flag_op(id.op) & (id.rd != '0),
                  is_load: id.is_load,
                  op:      id.op,
                  rd:      id.rd,
                  a:       fwd_a,
                  b:       id.use_imm ? id.imm : fwd_b};
      end else begin
        ex_q.valid <= 1'b0;
        ex_q.we    <= 1'b0;
      end
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_we      = ex_q.we;
  assign ex_is_load = ex_q.is_load;
  assign ex_op      = ex_q.op;
  assign ex_rd      = ex_q.rd;
  assign ex_a       = ex_q.a;
  assign ex_b       = ex_q.b;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_scalar_operand_stage.sv
// Self-checking bench for scalar_operand_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a model.
module tb_scalar_operand_stage;
  import scalar_pkg::*;

  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic              id_ready;
  logic [OP_W-1:0]   id_op;
  logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
  logic              id_rd_we, id_is_load, id_use_imm;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, alu_result;
  logic              wb_we;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ex_stall, flush;
  logic              ex_valid, ex_we, ex_is_load;
  logic [DATA_W-1:0] ex_a, ex_b;
  logic [OP_W-1:0]   ex_op;
  logic [REG_W-1:0]  ex_rd;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  scalar_operand_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_use_imm(id_use_imm), .id_imm(id_imm),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_result(alu_result),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {ACT_SQUASH, ACT_HOLD, ACT_BUBBLE, ACT_TAKE, ACT_IDLE} act_e;

  bit                m_valid, m_we, m_ld;
  logic [DATA_W-1:0] m_a, m_b;
  logic [OP_W-1:0]   m_op;
  logic [REG_W-1:0]  m_rd;
  int                m_cnt;

  function automatic bit m_hazard();
    if (!(id_valid && m_valid && m_ld && m_we && m_rd != 0)) return 1'b0;
    return (id_rs1 == m_rd) || (!id_use_imm && id_rs2 == m_rd);
  endfunction

  function automatic bit m_ready();
    return flush || (!ex_stall && !m_hazard());
  endfunction

  function automatic act_e m_action();
    if (flush)      return ACT_SQUASH;
    if (ex_stall)   return ACT_HOLD;
    if (m_hazard()) return ACT_BUBBLE;
    if (id_valid)   return ACT_TAKE;
    return ACT_IDLE;
  endfunction

  // Value a source register must carry: the newest producer wins.
  function automatic logic [DATA_W-1:0] m_src(input logic [REG_W-1:0] rs,
                                               input logic [DATA_W-1:0] rf);
    if (rs == 0) return '0;
    if (m_valid && m_we && !m_ld && m_rd == rs) return alu_result;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_we = 0; m_ld = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_cnt = 0;
    end else begin
      case (m_action())
        ACT_HOLD: ;
        ACT_BUBBLE: begin
          m_valid = 0; m_we = 0;
          m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        ACT_TAKE: begin
          m_a     = m_src(id_rs1, rf_rdata1);
          m_b     = id_use_imm ? id_imm : m_src(id_rs2, rf_rdata2);
          m_valid = 1;
          m_we    = id_rd_we && (id_op < 8) && (id_rd != 0);
          m_ld    = id_is_load;
          m_op    = id_op;
          m_rd    = id_rd;
        end
        default: begin m_valid = 0; m_we = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ex_valid", ex_valid, m_valid);
      check("m_ex_we", ex_we, m_we);
      check("m_stall_cnt", stall_cnt, m_cnt);
      check("m_id_ready", id_ready, m_ready());
      if (m_valid) begin
        check("m_ex_a", ex_a, m_a);
        check("m_ex_b", ex_b, m_b);
        check("m_ex_op", ex_op, m_op);
        check("m_ex_rd", ex_rd, m_rd);
        check("m_ex_is_load", ex_is_load, m_ld);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rs1, rs2, rd,
                       input logic we, ld, ui, input logic [DATA_W-1:0] imm);
    id_valid = 1; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd_we = we; id_is_load = ld; id_use_imm = ui; id_imm = imm;
  endtask

  task automatic set_rf(input logic [DATA_W-1:0] d1, d2);
    rf_rdata1 = d1; rf_rdata2 = d2;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  initial begin
    rst_n = 0; id_valid = 0; ex_stall = 0; flush = 0; wb_we = 0; wb_rd = '0; wb_data = '0;
    alu_result = '0;
    issue(4'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, '0);
    id_valid = 0;
    set_rf('0, '0);
    step(); step();
    rst_n = 1;
    check("reset_valid", ex_valid, 0);
    check("reset_we", ex_we, 0);
    check("reset_a", ex_a, 0);
    check("reset_cnt", stall_cnt, 0);
    chk_en = 1;

    // Back-to-back dependency resolved through the EX bypass.
    issue(OP_ADD, 5'd1, 5'd2, 5'd3, 1, 0, 0, '0); set_rf(36'd5, 36'd7);
    step();
    check("t1_add_a", ex_a, 5);
    check("t1_add_b", ex_b, 7);
    issue(OP_SUB, 5'd3, 5'd1, 5'd4, 1, 0, 0, '0); set_rf(36'd0, 36'd5); alu_result = 36'd12;
    #1 check("t1_ready", id_ready, 1);
    step();
    check("t1_sub_a", ex_a, 12);
    check("t1_sub_b", ex_b, 5);
    check("t1_sub_op", ex_op, 1);

    // Load-use: one bubble, then the WB value is picked up.
    issue(OP_ADD, 5'd1, 5'd0, 5'd5, 1, 1, 1, 36'h10); set_rf(36'd5, 36'd0);
    step();
    issue(OP_ADD, 5'd5, 5'd1, 5'd6, 1, 0, 0, '0); set_rf(36'd0, 36'd5); alu_result = 36'h15;
    #1 check("t2_ready_low", id_ready, 0);
    step();
    check("t2_bubble_valid", ex_valid, 0);
    check("t2_cnt", stall_cnt, 1);
    wb_we = 1; wb_rd = 5'd5; wb_data = 36'h33; alu_result = 36'hDEAD;
    #1 check("t2_ready_high", id_ready, 1);
    step();
    check("t2_a_from_wb", ex_a, 36'h33);
    check("t2_b", ex_b, 5);

    // WB bypass of a wide value; r0 ignores a WB write to r0.
    issue(OP_ADD, 5'd0, 5'd2, 5'd8, 1, 0, 0, '0); set_rf(36'h123, 36'd0);
    wb_we = 1; wb_rd = 5'd2; wb_data = 36'h9_0000_0001; alu_result = 36'hAAA;
    step();
    check("t3_b_wb", ex_b, 36'h9_0000_0001);
    check("t3_a_r0", ex_a, 0);
    issue(OP_ADD, 5'd0, 5'd9, 5'd8, 1, 0, 0, '0); set_rf(36'h777, 36'h42);
    wb_rd = 5'd0; wb_data = 36'h555;
    step();
    check("t3_r0_wb0", ex_a, 0);
    check("t3_b_rf", ex_b, 36'h42);
    wb_we = 0;

    // Downstream stall holds EX; flush overrides it.
    issue(OP_MUL, 5'd1, 5'd2, 5'd10, 1, 0, 0, '0); set_rf(36'd5, 36'd7);
    step();
    ex_stall = 1;
    issue(OP_SUB, 5'd10, 5'd1, 5'd11, 1, 0, 0, '0); set_rf(36'h99, 36'd5);
    #1 check("t4_ready_stall", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_valid", ex_valid, 1);
      check("t4_hold_a", ex_a, 5);
      check("t4_hold_b", ex_b, 7);
      check("t4_hold_op", ex_op, 2);
      check("t4_hold_rd", ex_rd, 10);
      check("t4_ready", id_ready, 0);
    end
    flush = 1;
    #1 check("t4_ready_flush", id_ready, 1);
    step();
    check("t4_flush_valid", ex_valid, 0);
    check("t4_flush_we", ex_we, 0);
    flush = 0; ex_stall = 0;

    // Compare op never writes a register; immediate replaces rs2.
    issue(4'b1000, 5'd1, 5'd3, 5'd7, 1, 0, 1, 36'hF_FFFF_FFFF); set_rf(36'd5, 36'd1);
    step();
    check("t5_valid", ex_valid, 1);
    check("t5_we", ex_we, 0);
    check("t5_imm", ex_b, 36'hF_FFFF_FFFF);

    // Repeated load-use bubbles drive the counter into saturation.
    for (int i = 0; i < 16; i++) begin
      issue(OP_ADD, 5'd1, 5'd0, 5'd5, 1, 1, 1, 36'd4); set_rf(36'd5, 36'd0);
      step();
      issue(OP_ADD, 5'd5, 5'd2, 5'd6, 1, 0, 0, '0); set_rf(36'd0, 36'd7);
      step();
      check("t6_cnt", stall_cnt, ((2 + i) > CNT_MAX) ? CNT_MAX : (2 + i));
      step();
    end
    check("t6_sat", stall_cnt, CNT_MAX);

    // Reset mid-stream discards the in-flight instruction.
    issue(OP_XOR, 5'd1, 5'd2, 5'd12, 1, 1, 0, '0); set_rf(36'h11, 36'h22);
    step();
    rst_n = 0;
    step();
    check("t6_rst_valid", ex_valid, 0);
    check("t6_rst_we", ex_we, 0);
    check("t6_rst_load", ex_is_load, 0);
    check("t6_rst_a", ex_a, 0);
    check("t6_rst_b", ex_b, 0);
    check("t6_rst_op", ex_op, 0);
    check("t6_rst_rd", ex_rd, 0);
    check("t6_rst_cnt", stall_cnt, 0);
    rst_n = 1;

    // Randomized traffic; small register range keeps hazards and bypass hits frequent.
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(399) != 0);
      id_valid   = ($urandom_range(3) != 0);
      id_op      = OP_W'($urandom_range(15));
      id_rs1     = REG_W'($urandom_range(7));
      id_rs2     = REG_W'($urandom_range(7));
      id_rd      = REG_W'($urandom_range(7));
      id_rd_we   = ($urandom_range(4) != 0);
      id_is_load = ($urandom_range(2) == 0);
      id_use_imm = ($urandom_range(3) == 0);
      id_imm     = rnd_data();
      rf_rdata1  = rnd_data();
      rf_rdata2  = rnd_data();
      alu_result = rnd_data();
      wb_we      = ($urandom_range(1) == 1);
      wb_rd      = REG_W'($urandom_range(7));
      wb_data    = rnd_data();
      ex_stall   = ($urandom_range(4) == 0);
      flush      = ($urandom_range(15) == 0);
      step();
    end

    rst_n = 1; id_valid = 0; ex_stall = 0; flush = 0; wb_we = 0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
